// File: rtl/dtm_pkg.sv
// Shared types and constants for the RISC-V JTAG debug transport module.
package dtm_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR_SCAN,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR_SCAN,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } jtag_state_t;

    typedef enum logic [1:0] {
        INSTR_BYPASS,
        INSTR_IDCODE,
        INSTR_DTMCS,
        INSTR_DMI
    } dtm_instr_t;

    localparam logic [7:0] IR_IDCODE = 8'h01;
    localparam logic [7:0] IR_DTMCS  = 8'h10;
    localparam logic [7:0] IR_DMI    = 8'h11;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_t;

    localparam logic [1:0] DMI_ST_OK     = 2'd0;
    localparam logic [1:0] DMI_ST_FAILED = 2'd2;
    localparam logic [1:0] DMI_ST_BUSY   = 2'd3;

    localparam int DTMCS_DMIRESET     = 16;
    localparam int DTMCS_DMIHARDRESET = 17;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: the 16-state machine driven by tms.
module jtag_tap_fsm
    import dtm_pkg::*;
(
    input  logic        tclk,
    input  logic        trst,
    input  logic        tms,
    output jtag_state_t state
);

    jtag_state_t state_d;

    always_ff @(posedge tclk) begin
        if (trst) state <= TEST_LOGIC_RESET;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        endcase
    end

endmodule

// File: rtl/dtm_jtag_dmi.sv
// RISC-V JTAG DTM: TAP, IR, IDCODE/BYPASS/DTMCS/DMI data registers and
// the valid/ready DMI request/response handshake toward the debug module.
module dtm_jtag_dmi
    import dtm_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 5,
    parameter int unsigned ABITS        = 7,
    parameter logic [31:0] IDCODE_VALUE = 32'h1BEEF001,
    parameter logic [2:0]  IDLE_HINT    = 3'd1
) (
    input  logic             tclk,
    input  logic             trst,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);

    localparam int unsigned DMI_W = ABITS + 34;

    jtag_state_t state;

    jtag_tap_fsm u_tap (
        .tclk  (tclk),
        .trst  (trst),
        .tms   (tms),
        .state (state)
    );

    logic [IR_WIDTH-1:0] ir_q, ir_shift_q, ir_shift_d;
    logic [DMI_W-1:0]    dr_q, dr_d, dr_cap;
    logic [31:0]         dtmcs_cap;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [1:0]          sticky_q, sticky_d, sticky_rsp;
    logic                busy_q, busy_d, busy_rsp;
    logic                req_valid_d, issue, resp_fire;
    logic                cap_dmi, upd_dmi, upd_dtmcs, hard_upd, soft_upd;
    logic                shift_dr_next, shift_ir_next, tdo_d;
    dtm_instr_t          instr;

    always_comb begin
        instr = INSTR_BYPASS;
        if      (ir_q == IR_WIDTH'(IR_IDCODE)) instr = INSTR_IDCODE;
        else if (ir_q == IR_WIDTH'(IR_DTMCS))  instr = INSTR_DTMCS;
        else if (ir_q == IR_WIDTH'(IR_DMI))    instr = INSTR_DMI;
    end

    assign cap_dmi   = (state == CAPTURE_DR) && (instr == INSTR_DMI);
    assign upd_dmi   = (state == UPDATE_DR)  && (instr == INSTR_DMI);
    assign upd_dtmcs = (state == UPDATE_DR)  && (instr == INSTR_DTMCS);
    assign hard_upd  = upd_dtmcs && dr_q[DTMCS_DMIHARDRESET];
    assign soft_upd  = upd_dtmcs && dr_q[DTMCS_DMIRESET];

    // A response that lands with a hardreset, or with nothing outstanding, is dropped
    assign resp_fire = dmi_resp_valid && busy_q && !hard_upd;

    always_comb begin
        sticky_rsp = sticky_q;
        if (resp_fire && dmi_resp_op[1] && (sticky_q == DMI_ST_OK))
            sticky_rsp = dmi_resp_op;
        busy_rsp    = busy_q && !resp_fire;
        resp_data_d = resp_fire ? dmi_resp_data : resp_data_q;

        sticky_d = sticky_rsp;
        busy_d   = busy_rsp;
        issue    = 1'b0;
        if (cap_dmi && busy_rsp && (sticky_rsp == DMI_ST_OK))
            sticky_d = DMI_ST_BUSY;
        if (upd_dmi) begin
            if (busy_rsp) begin
                if (sticky_rsp == DMI_ST_OK) sticky_d = DMI_ST_BUSY;
            end else if ((sticky_rsp == DMI_ST_OK) &&
                         ((dr_q[1:0] == DMI_OP_READ) || (dr_q[1:0] == DMI_OP_WRITE))) begin
                issue  = 1'b1;
                busy_d = 1'b1;
            end
        end
        if (soft_upd || hard_upd) sticky_d = DMI_ST_OK;
        if (hard_upd)             busy_d   = 1'b0;

        req_valid_d = dmi_req_valid;
        if (hard_upd)                           req_valid_d = 1'b0;
        else if (issue)                         req_valid_d = 1'b1;
        else if (dmi_req_valid && dmi_req_ready) req_valid_d = 1'b0;
    end

    assign dtmcs_cap = {14'b0, 2'b0, 1'b0, IDLE_HINT, sticky_q, 6'(ABITS), 4'd1};

    always_comb begin
        unique case (instr)
            INSTR_IDCODE: dr_cap = DMI_W'(IDCODE_VALUE);
            INSTR_DTMCS:  dr_cap = DMI_W'(dtmcs_cap);
            INSTR_DMI:    dr_cap = {dmi_req_addr, resp_data_d, sticky_d};
            default:      dr_cap = '0;
        endcase
    end

    // Registers are kept LSB-aligned; tdi enters at the selected register's MSB
    always_comb begin
        dr_d = dr_q;
        if (state == CAPTURE_DR) begin
            dr_d = dr_cap;
        end else if (state == SHIFT_DR) begin
            dr_d = dr_q >> 1;
            unique case (instr)
                INSTR_IDCODE, INSTR_DTMCS: dr_d[31]      = tdi;
                INSTR_DMI:                 dr_d[DMI_W-1] = tdi;
                default:                   dr_d[0]       = tdi;
            endcase
        end
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        if (state == CAPTURE_IR)    ir_shift_d = IR_WIDTH'(IR_CAPTURE);
        else if (state == SHIFT_IR) ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
    end

    // tdo is registered, so look one state ahead to present the LSB on entry to SHIFT
    assign shift_dr_next = !tms && (state inside {CAPTURE_DR, SHIFT_DR, EXIT2_DR});
    assign shift_ir_next = !tms && (state inside {CAPTURE_IR, SHIFT_IR, EXIT2_IR});
    assign tdo_d  = shift_dr_next ? dr_d[0] : (shift_ir_next ? ir_shift_d[0] : 1'b0);
    assign tdo_en = (state == SHIFT_DR) || (state == SHIFT_IR);
    assign dmi_resp_ready = 1'b1;

    always_ff @(posedge tclk) begin
        ir_shift_q  <= ir_shift_d;
        dr_q        <= dr_d;
        resp_data_q <= resp_data_d;
    end

    always_ff @(posedge tclk) begin
        if (trst) begin
            ir_q          <= IR_WIDTH'(IR_IDCODE);
            tdo           <= 1'b0;
            sticky_q      <= DMI_ST_OK;
            busy_q        <= 1'b0;
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= '0;
        end else begin
            if (state == TEST_LOGIC_RESET) ir_q <= IR_WIDTH'(IR_IDCODE);
            else if (state == UPDATE_IR)   ir_q <= ir_shift_q;
            tdo           <= tdo_d;
            sticky_q      <= sticky_d;
            busy_q        <= busy_d;
            dmi_req_valid <= req_valid_d;
            if (issue) begin
                dmi_req_addr <= dr_q[DMI_W-1:34];
                dmi_req_data <= dr_q[33:2];
                dmi_req_op   <= dr_q[1:0];
            end
        end
    end

endmodule

// File: tb/tb_dtm_jtag_dmi.sv
// Directed-vector bench for dtm_jtag_dmi: TAP scans, DTMCS and DMI transactions.
module tb_dtm_jtag_dmi;

    localparam int IRW = 5;
    localparam int AB  = 7;
    localparam int DW  = AB + 34;

    logic          tclk = 1'b0;
    logic          trst = 1'b1;
    logic          tms  = 1'b1;
    logic          tdi  = 1'b0;
    logic          tdo, tdo_en;
    logic          dmi_req_valid;
    logic          dmi_req_ready = 1'b0;
    logic [AB-1:0] dmi_req_addr;
    logic [31:0]   dmi_req_data;
    logic [1:0]    dmi_req_op;
    logic          dmi_resp_valid = 1'b0;
    logic          dmi_resp_ready;
    logic [31:0]   dmi_resp_data = '0;
    logic [1:0]    dmi_resp_op = '0;

    int n_vec = 0;
    int n_err = 0;

    dtm_jtag_dmi #(
        .IR_WIDTH(IRW), .ABITS(AB), .IDCODE_VALUE(32'h1BEEF001), .IDLE_HINT(3'd1)
    ) dut (
        .tclk(tclk), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op)
    );

    always #5 tclk = ~tclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    task automatic tck(input logic m, input logic d, output logic o, output logic en);
        @(negedge tclk);
        o  = tdo;
        en = tdo_en;
        tms = m;
        tdi = d;
        @(posedge tclk);
        #1;
    endtask

    task automatic step(input logic m);
        logic o, e;
        tck(m, 1'b0, o, e);
    endtask

    task automatic shift_ir(input logic [IRW-1:0] v, output logic [63:0] cap);
        logic o, e;
        cap = '0;
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < IRW; i++) begin
            tck(i == IRW - 1, v[i], o, e);
            cap[i] = o;
        end
        step(1'b1); step(1'b0);
    endtask

    task automatic shift_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
        logic o, e;
        dout = '0;
        step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < len; i++) begin
            tck(i == len - 1, din[i], o, e);
            dout[i] = o;
            if (i == 0 || i == len - 1) check_val("tdo_en_in_shift", {63'b0, e}, 64'd1);
        end
        step(1'b1); step(1'b0);
    endtask

    task automatic resp_pulse(input logic [31:0] d, input logic [1:0] op);
        @(negedge tclk);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = d;
        dmi_resp_op    = op;
        @(posedge tclk);
        #1;
        dmi_resp_valid = 1'b0;
    endtask

    task automatic ready_pulse();
        @(negedge tclk);
        dmi_req_ready = 1'b1;
        @(posedge tclk);
        #1;
        dmi_req_ready = 1'b0;
    endtask

    logic [63:0] r;

    initial begin
        // reset state
        repeat (3) @(posedge tclk);
        #1;
        check_val("rst_tdo", {63'b0, tdo}, 64'd0);
        check_val("rst_tdo_en", {63'b0, tdo_en}, 64'd0);
        check_val("rst_req_valid", {63'b0, dmi_req_valid}, 64'd0);
        check_val("rst_req_addr", {57'b0, dmi_req_addr}, 64'd0);
        check_val("rst_req_data", {32'b0, dmi_req_data}, 64'd0);
        check_val("rst_req_op", {62'b0, dmi_req_op}, 64'd0);
        check_val("rst_resp_ready", {63'b0, dmi_resp_ready}, 64'd1);
        @(negedge tclk);
        trst = 1'b0;
        step(1'b0);
        check_val("idle_tdo_en", {63'b0, tdo_en}, 64'd0);

        // IDCODE selected by reset
        shift_dr(64'd0, 32, r);
        check_val("idcode", r, 64'h1BEEF001);
        check_val("post_scan_tdo_en", {63'b0, tdo_en}, 64'd0);

        // BYPASS via all-ones and via an unassigned code
        shift_ir(5'h1F, r);
        check_val("ir_capture", r, 64'h01);
        shift_dr(64'h0A5, 9, r);
        check_val("bypass_1f", r, 64'h14A);
        shift_ir(5'h07, r);
        shift_dr(64'h0A5, 9, r);
        check_val("bypass_07", r, 64'h14A);

        // five tms=1 from SHIFT_DR return to reset, restoring IDCODE
        step(1'b1); step(1'b0); step(1'b0);
        repeat (5) step(1'b1);
        step(1'b0);
        shift_dr(64'd0, 32, r);
        check_val("idcode_after_tlr", r, 64'h1BEEF001);

        // DTMCS
        shift_ir(5'h10, r);
        shift_dr(64'd0, 32, r);
        check_val("dtmcs", r, 64'h1071);

        // DMI write with stalled ready, response in the accept cycle
        shift_ir(5'h11, r);
        shift_dr(dmi_word(7'h10, 32'hDEADBEEF, 2'd2), DW, r);
        check_val("wr_valid", {63'b0, dmi_req_valid}, 64'd1);
        check_val("wr_addr", {57'b0, dmi_req_addr}, 64'h10);
        check_val("wr_data", {32'b0, dmi_req_data}, 64'hDEADBEEF);
        check_val("wr_op", {62'b0, dmi_req_op}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check_val("wr_valid_stall", {63'b0, dmi_req_valid}, 64'd1);
            check_val("wr_data_stall", {32'b0, dmi_req_data}, 64'hDEADBEEF);
        end
        @(negedge tclk);
        dmi_req_ready  = 1'b1;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h12345678;
        dmi_resp_op    = 2'd0;
        @(posedge tclk);
        #1;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        check_val("wr_valid_drop", {63'b0, dmi_req_valid}, 64'd0);

        // rescan shows write response; its update issues a read
        shift_dr(dmi_word(7'h05, 32'h0, 2'd1), DW, r);
        check_val("rescan_after_wr", r, dmi_word(7'h10, 32'h12345678, 2'd0));
        check_val("rd_valid", {63'b0, dmi_req_valid}, 64'd1);
        check_val("rd_addr", {57'b0, dmi_req_addr}, 64'h05);
        check_val("rd_op", {62'b0, dmi_req_op}, 64'd1);
        ready_pulse();
        check_val("rd_valid_drop", {63'b0, dmi_req_valid}, 64'd0);
        step(1'b0); step(1'b0);
        resp_pulse(32'hCAFEF00D, 2'd0);

        // busy path: read outstanding, rescan before response
        shift_dr(dmi_word(7'h22, 32'h0, 2'd1), DW, r);
        check_val("rescan_after_rd", r, dmi_word(7'h05, 32'hCAFEF00D, 2'd0));
        check_val("busy_rd_valid", {63'b0, dmi_req_valid}, 64'd1);
        ready_pulse();
        shift_dr(dmi_word(7'h33, 32'h0, 2'd1), DW, r);
        check_val("busy_capture", r, dmi_word(7'h22, 32'hCAFEF00D, 2'd3));
        check_val("busy_no_issue", {63'b0, dmi_req_valid}, 64'd0);
        check_val("busy_addr_kept", {57'b0, dmi_req_addr}, 64'h22);
        resp_pulse(32'hBBBB0001, 2'd0);
        shift_dr(dmi_word(7'h00, 32'h0, 2'd0), DW, r);
        check_val("sticky_holds", r, dmi_word(7'h22, 32'hBBBB0001, 2'd3));
        shift_ir(5'h10, r);
        shift_dr(64'h0001_0000, 32, r);
        check_val("dtmcs_dmistat_busy", r, 64'h1C71);
        shift_ir(5'h11, r);
        shift_dr(dmi_word(7'h00, 32'h0, 2'd0), DW, r);
        check_val("after_dmireset", r, dmi_word(7'h22, 32'hBBBB0001, 2'd0));

        // dmihardreset with request outstanding, late failing response
        shift_dr(dmi_word(7'h44, 32'h55, 2'd2), DW, r);
        check_val("hr_valid", {63'b0, dmi_req_valid}, 64'd1);
        shift_ir(5'h10, r);
        check_val("hr_valid_held", {63'b0, dmi_req_valid}, 64'd1);
        shift_dr(64'h0002_0000, 32, r);
        check_val("hr_dtmcs", r, 64'h1071);
        check_val("hr_valid_drop", {63'b0, dmi_req_valid}, 64'd0);
        resp_pulse(32'h00000099, 2'd2);
        shift_ir(5'h11, r);
        shift_dr(dmi_word(7'h00, 32'h0, 2'd0), DW, r);
        check_val("hr_late_resp_dropped", r, dmi_word(7'h44, 32'hBBBB0001, 2'd0));

        // trst with request outstanding
        shift_dr(dmi_word(7'h0A, 32'h0, 2'd1), DW, r);
        check_val("trst_valid_before", {63'b0, dmi_req_valid}, 64'd1);
        @(negedge tclk);
        trst = 1'b1;
        @(posedge tclk);
        #1;
        check_val("trst_valid_drop", {63'b0, dmi_req_valid}, 64'd0);
        check_val("trst_addr", {57'b0, dmi_req_addr}, 64'd0);
        check_val("trst_resp_ready", {63'b0, dmi_resp_ready}, 64'd1);
        @(negedge tclk);
        trst = 1'b0;
        resp_pulse(32'h00000077, 2'd3);
        step(1'b0);
        shift_ir(5'h11, r);
        shift_dr(dmi_word(7'h00, 32'h0, 2'd0), DW, r);
        check_val("trst_late_op", {62'b0, r[1:0]}, 64'd0);
        check_val("trst_late_data", {32'b0, r[33:2]}, 64'hBBBB0001);
        check_val("trst_no_issue", {63'b0, dmi_req_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
